// File: rtl/divfreq_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable divider.
// Channel phase alignment is available when DIVFREQ_SYNC_EN is defined.
package divfreq_pkg;

   localparam int DIVFREQ_CNT_W = 25;

   // Half-periods for a 50 MHz board clock.
   localparam int unsigned HALF_1HZ   = 25000000;
   localparam int unsigned HALF_100HZ = 250000;
   localparam int unsigned HALF_1KHZ  = 25000;
   localparam int unsigned HALF_10KHZ = 2500;

   function automatic int unsigned half_from_hz(input int unsigned f_clk,
                                                input int unsigned f_out);
      int unsigned h;
      h = (f_out == 0) ? 32'd1 : f_clk / (2 * f_out);
      if (h < 1) begin
         h = 1;
      end
      return h;
   endfunction

endpackage

// File: rtl/divfreq_chan.sv
// One divider channel: 50% square output, rising-edge tick strobe and a
// pending divisor that only takes effect at a half-period boundary.
module divfreq_chan
   import divfreq_pkg::*;
#(
   parameter int          CNT_W    = DIVFREQ_CNT_W,
   parameter int unsigned DEF_HALF = HALF_1HZ
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
`ifdef DIVFREQ_SYNC_EN
   input  logic             sync_i,
`endif
   input  logic             en_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] half_i,
   output logic             clk_out_o,
   output logic             tick_o,
   output logic             pend_o
);

   localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEF_HALF);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] pend_half_q, pend_half_d;
   logic             out_q, out_d;
   logic             tick_q, tick_d;
   logic             pend_q, pend_d;
   logic             force_idle;
   logic             wrap;
   logic             apply;
   logic [CNT_W-1:0] last_cnt;

   // A half of zero behaves as one, so the terminal count is clamped at 0.
   assign last_cnt = (half_q == '0) ? '0 : half_q - CNT_W'(1);
   assign wrap     = (cnt_q == last_cnt);

`ifdef DIVFREQ_SYNC_EN
   assign force_idle = sync_i | ~en_i;
`else
   assign force_idle = ~en_i;
`endif

   always_comb begin
      cnt_d       = cnt_q;
      out_d       = out_q;
      tick_d      = 1'b0;
      half_d      = half_q;
      pend_half_d = pend_half_q;
      pend_d      = pend_q;
      apply       = 1'b0;

      if (force_idle) begin
         cnt_d = '0;
         out_d = 1'b0;
         apply = pend_q;
      end else if (wrap) begin
         cnt_d  = '0;
         out_d  = ~out_q;
         tick_d = ~out_q;
         apply  = pend_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (apply) begin
         half_d = pend_half_q;
         pend_d = 1'b0;
      end
      // A load on the boundary edge stays pending for the following boundary.
      if (load_i) begin
         pend_half_d = half_i;
         pend_d      = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q       <= '0;
         out_q       <= 1'b0;
         tick_q      <= 1'b0;
         pend_q      <= 1'b0;
         half_q      <= DEF_HALF_C;
         pend_half_q <= DEF_HALF_C;
      end else begin
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         tick_q      <= tick_d;
         pend_q      <= pend_d;
         half_q      <= half_d;
         pend_half_q <= pend_half_d;
      end
   end

   assign clk_out_o = out_q;
   assign tick_o    = tick_q;
   assign pend_o    = pend_q;

endmodule

// File: rtl/divfreq_multi.sv
// CH independent programmable dividers producing square waves and tick strobes.
// Defining DIVFREQ_SYNC_EN adds sync_i, which phase-aligns all channels.
module divfreq_multi
   import divfreq_pkg::*;
#(
   parameter int          CH       = 4,
   parameter int          CNT_W    = DIVFREQ_CNT_W,
   parameter int unsigned DEF_HALF = HALF_1HZ
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
`ifdef DIVFREQ_SYNC_EN
   input  logic                sync_i,
`endif
   input  logic [CH-1:0]       en_i,
   input  logic [CH*CNT_W-1:0] div_half_i,
   input  logic [CH-1:0]       div_load_i,
   output logic [CH-1:0]       clk_out_o,
   output logic [CH-1:0]       tick_o,
   output logic [CH-1:0]       pend_o
);

   for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      divfreq_chan #(
         .CNT_W    (CNT_W),
         .DEF_HALF (DEF_HALF)
      ) u_chan (
         .clk_i     (clk_i),
         .rst_n_i   (rst_n_i),
`ifdef DIVFREQ_SYNC_EN
         .sync_i    (sync_i),
`endif
         .en_i      (en_i[gi]),
         .load_i    (div_load_i[gi]),
         .half_i    (div_half_i[gi*CNT_W +: CNT_W]),
         .clk_out_o (clk_out_o[gi]),
         .tick_o    (tick_o[gi]),
         .pend_o    (pend_o[gi])
      );
   end

endmodule
